irq_coalescer: RTL and testbench

IRQ_COALESCER -- requirements
Module: irq_coalescer

---
 rtl/irq_coalescer.sv | 181 ++++++++++++++++++
 tb/tb_irq_coalescer.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_coalescer.sv
// Interrupt coalescer: latches timer edges into PENDING, raises one CPU irq per burst.
// Define IRQ_COALESCER_HOLDOFF_EN to add the HOLDOFF register, counter and state.
module irq_coalescer (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  irq_in,
    input  logic [2:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [15:0] writedata,
    output logic [15:0] readdata,
    output logic        irq
);

`ifdef IRQ_COALESCER_HOLDOFF_EN
    typedef enum logic [1:0] {StIdle, StAssert, StHoldoff} state_e;
`else
    typedef enum logic [1:0] {StIdle, StAssert} state_e;
`endif

    state_e      state_q, state_d;
    logic        irq_d;
    logic [7:0]  irq_q;
    logic [7:0]  pending_q, pending_d;
    logic [7:0]  mask_q, mask_d;
    logic [3:0]  thresh_q, thresh_d;
    logic [15:0] evcount_q, evcount_d;
    logic [3:0]  ccount_q, ccount_d;
    logic [15:0] readdata_d;

    logic [7:0]  edges, pm, pm_next, pend_clr;
    logic        wr;
    logic [3:0]  eff_thresh;
    logic [16:0] ev_sum;
    logic [4:0]  cc_sum;
    logic [2:0]  active_idx;

`ifdef IRQ_COALESCER_HOLDOFF_EN
    logic [15:0] holdoff_q, holdoff_d;
    logic [15:0] hcnt_q, hcnt_d;
`else
    logic unused_wdata_hi;
    assign unused_wdata_hi = ^writedata[15:8];
`endif

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + {3'd0, v[i]};
        return n;
    endfunction

    assign edges      = irq_in & ~irq_q;
    assign wr         = chipselect & ~write_n;
    assign pm         = pending_q & mask_q;
    assign pm_next    = pending_d & mask_d;
    assign eff_thresh = (thresh_q == 4'd0) ? 4'd1 : thresh_q;
    assign pend_clr   = (wr && address == 3'd0) ? writedata[7:0] : 8'd0;
    assign ev_sum     = {1'b0, evcount_q} + {13'd0, popcount8(edges)};
    assign cc_sum     = {1'b0, ccount_q} + {1'b0, popcount8(edges & mask_q)};

    always_comb begin
        active_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pm[i]) active_idx = 3'(i);
        end
    end

    // Register file next-state; an edge beats a same-cycle W1C.
    always_comb begin
        pending_d = (pending_q & ~pend_clr) | edges;
        mask_d    = (wr && address == 3'd1) ? writedata[7:0] : mask_q;
        thresh_d  = (wr && address == 3'd3) ? writedata[3:0] : thresh_q;
        if (wr && address == 3'd5) evcount_d = 16'd0;
        else if (ev_sum[16])       evcount_d = 16'hFFFF;
        else                       evcount_d = ev_sum[15:0];
`ifdef IRQ_COALESCER_HOLDOFF_EN
        holdoff_d = (wr && address == 3'd4) ? writedata : holdoff_q;
`endif
    end

    always_comb begin
        unique case (address)
            3'd0:    readdata_d = {8'd0, pending_q};
            3'd1:    readdata_d = {8'd0, mask_q};
            3'd2:    readdata_d = {|pm, 12'd0, active_idx};
            3'd3:    readdata_d = {12'd0, thresh_q};
`ifdef IRQ_COALESCER_HOLDOFF_EN
            3'd4:    readdata_d = holdoff_q;
`endif
            3'd5:    readdata_d = evcount_q;
            default: readdata_d = 16'd0;
        endcase
    end

    // FSM next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (ccount_q >= eff_thresh && |pm) state_d = StAssert;
            end
            StAssert: begin
                if (!(|pm)) begin
`ifdef IRQ_COALESCER_HOLDOFF_EN
                    state_d = (holdoff_q != 16'd0) ? StHoldoff : StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef IRQ_COALESCER_HOLDOFF_EN
            StHoldoff: begin
                if (hcnt_q <= 16'd1) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // FSM output, registered so irq tracks the ASSERT state exactly
    always_comb begin
        irq_d = (state_d == StAssert);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            irq     <= 1'b0;
        end else begin
            state_q <= state_d;
            irq     <= irq_d;
        end
    end

    // Leftover work on return to IDLE preloads the count so ASSERT re-enters at once.
    always_comb begin
        ccount_d = ccount_q;
        if (state_q == StIdle) begin
            if (state_d == StAssert)  ccount_d = 4'd0;
            else if (cc_sum > 5'd15)  ccount_d = 4'hF;
            else                      ccount_d = cc_sum[3:0];
        end else if (state_d == StIdle && |pm_next) begin
            ccount_d = eff_thresh;
        end
`ifdef IRQ_COALESCER_HOLDOFF_EN
        hcnt_d = hcnt_q;
        if (state_q == StAssert && state_d == StHoldoff) hcnt_d = holdoff_q;
        else if (state_q == StHoldoff && hcnt_q != 16'd0) hcnt_d = hcnt_q - 16'd1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= 8'd0;
            pending_q <= 8'd0;
            mask_q    <= 8'd0;
            thresh_q  <= 4'd1;
            evcount_q <= 16'd0;
            ccount_q  <= 4'd0;
            readdata  <= 16'd0;
`ifdef IRQ_COALESCER_HOLDOFF_EN
            holdoff_q <= 16'd0;
            hcnt_q    <= 16'd0;
`endif
        end else begin
            irq_q     <= irq_in;
            pending_q <= pending_d;
            mask_q    <= mask_d;
            thresh_q  <= thresh_d;
            evcount_q <= evcount_d;
            ccount_q  <= ccount_d;
            readdata  <= readdata_d;
`ifdef IRQ_COALESCER_HOLDOFF_EN
            holdoff_q <= holdoff_d;
            hcnt_q    <= hcnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_irq_coalescer.sv
// Bench for irq_coalescer: directed scenarios plus random traffic against a behavioural model.
module tb_irq_coalescer;

`ifdef IRQ_COALESCER_HOLDOFF_EN
    localparam bit HoldEn = 1'b1;
`else
    localparam bit HoldEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_in = 8'd0;
    logic [2:0]  address = 3'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [15:0] writedata = 16'd0;
    logic [15:0] readdata;
    logic        irq;

    irq_coalescer dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Model state: modes 0 = idle, 1 = asserting, 2 = holding off
    logic [7:0]  m_prev, m_pend, m_mask;
    int          m_thr, m_hold, m_ev, m_cc, m_mode, m_left;
    logic        m_irq;
    logic [15:0] m_rd;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_step();
        logic [7:0]  e, pm, np, nm, clr;
        logic [15:0] rd;
        int          eff, lo, nmode, ncc, nleft, nev;
        bit          w;
        if (reset) begin
            m_prev = 0; m_pend = 0; m_mask = 0; m_thr = 1; m_hold = 0; m_ev = 0;
            m_cc = 0; m_mode = 0; m_left = 0; m_irq = 0; m_rd = 0;
            return;
        end
        e   = irq_in & ~m_prev;
        w   = chipselect && !write_n;
        pm  = m_pend & m_mask;
        eff = (m_thr == 0) ? 1 : m_thr;
        lo  = 0;
        for (int i = 7; i >= 0; i--) if (pm[i]) lo = i;
        case (address)
            3'd0:    rd = {8'h00, m_pend};
            3'd1:    rd = {8'h00, m_mask};
            3'd2:    rd = (pm != 0) ? (16'h8000 | 16'(lo)) : 16'h0000;
            3'd3:    rd = 16'(m_thr);
            3'd4:    rd = HoldEn ? 16'(m_hold) : 16'h0000;
            3'd5:    rd = 16'(m_ev);
            default: rd = 16'h0000;
        endcase
        clr = (w && address == 3'd0) ? writedata[7:0] : 8'h00;
        np  = (m_pend & ~clr) | e;
        nm  = (w && address == 3'd1) ? writedata[7:0] : m_mask;
        nev = (w && address == 3'd5) ? 0 : m_ev + $countones(e);
        if (nev > 65535) nev = 65535;
        nmode = m_mode; ncc = m_cc; nleft = m_left;
        if (m_mode == 0) begin
            if (m_cc >= eff && pm != 0) begin
                nmode = 1; ncc = 0;
            end else begin
                ncc = m_cc + $countones(e & m_mask);
                if (ncc > 15) ncc = 15;
            end
        end else if (m_mode == 1) begin
            if (pm == 0) begin
                if (HoldEn && m_hold != 0) begin
                    nmode = 2; nleft = m_hold;
                end else begin
                    nmode = 0;
                end
            end
        end else begin
            nleft = m_left - 1;
            if (nleft == 0) nmode = 0;
        end
        if (m_mode != 0 && nmode == 0 && (np & nm) != 0) ncc = eff;
        if (w && address == 3'd3) m_thr = int'(writedata[3:0]);
        if (HoldEn && w && address == 3'd4) m_hold = int'(writedata);
        m_prev = irq_in; m_pend = np; m_mask = nm; m_ev = nev;
        m_mode = nmode; m_cc = ncc; m_left = nleft;
        m_irq = (nmode == 1); m_rd = rd;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check_eq("irq", {31'd0, irq}, {31'd0, m_irq});
        check_eq("readdata", {16'd0, readdata}, {16'd0, m_rd});
    endtask

    task automatic bus_write(input logic [2:0] a, input logic [15:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] a, input logic [15:0] exp);
        address = a;
        tick();
        check_eq(tag, {16'd0, readdata}, {16'd0, exp});
    endtask

    task automatic pulse(input logic [7:0] b);
        irq_in = irq_in | b;
        tick();
        irq_in = irq_in & ~b;
        tick();
    endtask

    initial begin
        tick();
        tick();
        check_eq("reset_irq", {31'd0, irq}, 32'd0);
        check_eq("reset_rd", {16'd0, readdata}, 32'd0);
        reset = 1'b0;

        // single edge with everything enabled
        bus_write(3'd1, 16'h00FF);
        bus_write(3'd3, 16'h0001);
        pulse(8'h08);
        check_eq("single_irq", {31'd0, irq}, 32'd1);
        rd_check("single_pending", 3'd0, 16'h0008);
        rd_check("single_active", 3'd2, 16'h8003);
        bus_write(3'd0, 16'h00FF);
        tick();
        check_eq("single_clear_irq", {31'd0, irq}, 32'd0);

        // threshold of three
        bus_write(3'd3, 16'h0003);
        bus_write(3'd1, 16'h0001);
        bus_write(3'd5, 16'h0000);
        pulse(8'h01);
        check_eq("thr_p1", {31'd0, irq}, 32'd0);
        pulse(8'h01);
        tick();
        check_eq("thr_p2", {31'd0, irq}, 32'd0);
        pulse(8'h01);
        check_eq("thr_p3", {31'd0, irq}, 32'd1);
        rd_check("thr_evcount", 3'd5, 16'h0003);
        bus_write(3'd0, 16'h00FF);
        tick();

        // edge and W1C on the same bit in one cycle
        bus_write(3'd3, 16'h0001);
        bus_write(3'd1, 16'h0020);
        pulse(8'h20);
        irq_in = 8'h20; address = 3'd0; chipselect = 1'b1; write_n = 1'b0; writedata = 16'h0020;
        tick();
        irq_in = 8'h00; chipselect = 1'b0; write_n = 1'b1;
        tick();
        check_eq("setwins_irq", {31'd0, irq}, 32'd1);
        check_eq("setwins_pending", {16'd0, readdata}, 32'h20);
        bus_write(3'd0, 16'h00FF);
        tick();

        // masking the only pending line drops irq but keeps PENDING
        bus_write(3'd1, 16'h0004);
        pulse(8'h04);
        check_eq("mask_irq_on", {31'd0, irq}, 32'd1);
        bus_write(3'd1, 16'h0000);
        tick();
        check_eq("mask_irq_off", {31'd0, irq}, 32'd0);
        rd_check("mask_pending", 3'd0, 16'h0004);
        rd_check("mask_active", 3'd2, 16'h0000);
        bus_write(3'd0, 16'h00FF);
        bus_write(3'd1, 16'h00FF);

`ifdef IRQ_COALESCER_HOLDOFF_EN
        bus_write(3'd4, 16'd10);
        rd_check("hold_reg", 3'd4, 16'd10);
        pulse(8'h01);
        check_eq("hold_pre_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd0, 16'h00FF);
        for (int k = 1; k <= 11; k++) begin
            if (k == 3) irq_in = 8'h02;
            if (k == 4) irq_in = 8'h00;
            tick();
            check_eq($sformatf("hold_low_%0d", k), {31'd0, irq}, 32'd0);
        end
        tick();
        check_eq("hold_reassert", {31'd0, irq}, 32'd1);
        bus_write(3'd4, 16'd0);
        bus_write(3'd0, 16'h00FF);
        tick();
        tick();
`else
        bus_write(3'd4, 16'd50);
        rd_check("nohold_reg", 3'd4, 16'd0);
        pulse(8'h01);
        check_eq("nohold_pre_irq", {31'd0, irq}, 32'd1);
        bus_write(3'd0, 16'h00FF);
        tick();
        check_eq("nohold_idle", {31'd0, irq}, 32'd0);
`endif

        // reset while asserting
        pulse(8'h01);
        check_eq("rst_pre_irq", {31'd0, irq}, 32'd1);
        reset = 1'b1;
        tick();
        check_eq("rst_irq", {31'd0, irq}, 32'd0);
        reset = 1'b0;
        rd_check("rst_thresh", 3'd3, 16'h0001);
        rd_check("rst_pending", 3'd0, 16'h0000);

        // random traffic
        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'h01 << $urandom_range(0, 7));
            address    = 3'($urandom_range(0, 7));
            chipselect = ($urandom_range(0, 2) == 0);
            write_n    = ($urandom_range(0, 3) != 0);
            case (address)
                3'd3:    writedata = 16'($urandom_range(0, 4));
                3'd4:    writedata = 16'($urandom_range(0, 6));
                default: writedata = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 699) == 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
